tape_stream_ctrl: RTL
=====================

// Module: tape_stream_ctrl
// PURPOSE
//  Sequencer for the game-tape ROM behind the Z80 I/O ports.
//  - Decodes port strobes: IN GAME_PORT, OUT GAME_PORT and OUT CASS_PORT.
//  - Keeps one byte prefetched from a synchronous ROM, so IN returns data with no wait.
//  - Advances the tape address, handles rewind and motor control, and flags end-of-tape and overruns.
//  - Sits between tv80n I/O decode and the rom16 instance; rd_sel/rd_data feed the CPU read mux.
// PARAMETERS
//  AW        14       ROM address width
//  TAPE_LEN  16384    bytes on tape; valid addresses 0..TAPE_LEN-1 (1..2**AW)
//  GAME_PORT 8'h04    port for tape data read / rewind write
//  CASS_PORT 8'hFF    cassette control port; bit2 motor, bits1:0 audio
//  EOT_BYTE  8'h00    value returned by reads after end of tape
// PORTS
//  clk        in   1   system clock (cpuClock domain)
//  reset      in   1   asynchronous, active-high reset
//  ce         in   1   one-clk pulse on CPU clock-enable rising edge; strobes sampled only here
//  io_addr    in   8   cpuAddress[7:0]
//  io_rd_n    in   1   n_ioRD, active low
//  io_wr_n    in   1   n_ioWR, active low
//  io_dout    in   8   CPU data out
//  rom_addr   out  AW  ROM address; rom_data valid 1 clk after rom_addr changes
//  rom_data   in   8   ROM read data
//  rd_sel     out  1   combinational: io_addr==GAME_PORT && !io_rd_n
//  rd_data    out  8   byte for CPU; held stable between IN accesses
//  tape_bits  out  3   last value written to CASS_PORT bits 2:0
//  motor      out  1   tape_bits[2]
//  eot        out  1   high in state EOT
//  overrun    out  1   sticky; set when an IN hits state FETCH
// BEHAVIOUR
//  Reset (async):
//   - Outputs: rom_addr=0, rd_data=0, tape_bits=0, eot=0, overrun=0.
//   - Internal: buf=0, state=FETCH, fetch counter=0.
//  Strobe edge detect:
//   - At each ce, register prev_rd_n and prev_wr_n.
//   - Read event  = ce && io_addr==GAME_PORT && !io_rd_n && prev_rd_n.
//   - wr_game     = ce && io_addr==GAME_PORT && !io_wr_n && prev_wr_n.
//   - wr_cass     = same as wr_game with CASS_PORT.
//   - A held strobe produces exactly one event.
//  FSM (FETCH, READY, EOT):
//   - FETCH: wait 1 clk for ROM latency, then buf<=rom_data and go to READY. Total 2 clk from entry.
//   - READY, read event: rd_data<=buf; rom_addr<=rom_addr+1.
//     - If rom_addr+1 == TAPE_LEN (compare in AW+1 bits): go to EOT and leave rom_addr at TAPE_LEN-1.
//     - Otherwise go to FETCH.
//   - EOT, read event: rd_data<=EOT_BYTE; address unchanged.
//   - FETCH, read event: rd_data unchanged; overrun<=1; no address change.
//   - Rewind (wr_game in any state): rom_addr<=0, eot<=0, go to FETCH.
//     Any fetch already in progress is discarded and restarted.
//  Cassette write (wr_cass):
//   - tape_bits<=io_dout[2:0].
//   - If io_dout[2] && !tape_bits[2] (motor rising): perform rewind.
//   - Motor falling: no address effect.
//  Priority within one ce:
//   - Write events beat a read event; rewind beats increment.
//   - wr_game and wr_cass cannot coincide (single io_addr).
//  Other rules:
//   - overrun clears only on reset.
//   - Reset mid-fetch returns to FETCH at address 0.
//  Timing: ce spacing >= 3 clk guarantees no overrun (nominal spacing is 16).
// TESTING
//  1. ROM[0..2]=41,42,43; release reset; 3 IN events spaced 16 clk
//     -> rd_data 41,42,43; rom_addr=3; overrun=0.
//  2. IN held low across 4 ce pulses
//     -> a single read event; rom_addr advances by 1 only.
//  3. TAPE_LEN=4, read 5 times
//     -> 4th read returns ROM[3] and eot=1; 5th read returns 00; rom_addr=3.
//  4. After test 3, OUT CASS_PORT 04 (motor rising)
//     -> motor=1, eot=0, rom_addr=0; next IN returns ROM[0].
//     Then OUT 04 again -> no rewind.
//  5. OUT GAME_PORT 0 followed by IN one clk later (ce spacing 1)
//     -> overrun=1; rd_data unchanged. Next IN after 2 clk returns ROM[0].
//  6. Assert reset during FETCH
//     -> all outputs 0 immediately (async); after release, first IN returns ROM[0].

Source files
------------

// File: rtl/tape_stream_ctrl.sv
// Game-tape sequencer between the Z80 I/O decode and the tape ROM.
// Keeps one byte prefetched so IN from the game port never needs a wait state.
module tape_stream_ctrl #(
  parameter int unsigned AW        = 14,
  parameter int unsigned TAPE_LEN  = 16384,
  parameter logic [7:0]  GAME_PORT = 8'h04,
  parameter logic [7:0]  CASS_PORT = 8'hFF,
  parameter logic [7:0]  EOT_BYTE  = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic [7:0]    io_addr,
  input  logic          io_rd_n,
  input  logic          io_wr_n,
  input  logic [7:0]    io_dout,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic          rd_sel,
  output logic [7:0]    rd_data,
  output logic [2:0]    tape_bits,
  output logic          motor,
  output logic          eot,
  output logic          overrun
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_READY = 2'd1,
    ST_EOT   = 2'd2
  } state_e;

  // Compared one bit wider than the address so a full 2**AW tape still terminates.
  localparam logic [AW:0] TAPE_END = (AW+1)'(TAPE_LEN);

  state_e        state_q, state_d;
  logic          fetch_cnt_q, fetch_cnt_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]    buf_q, buf_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [2:0]    tape_bits_q, tape_bits_d;
  logic          eot_q, eot_d;
  logic          overrun_q, overrun_d;
  logic          prev_rd_n_q, prev_rd_n_d;
  logic          prev_wr_n_q, prev_wr_n_d;

  logic          game_hit_s;
  logic          cass_hit_s;
  logic          rd_ev_s;
  logic          wr_game_s;
  logic          wr_cass_s;
  logic          motor_rise_s;
  logic          rewind_s;
  logic          rd_eff_s;
  logic [AW:0]   addr_inc_s;
  logic [4:0]    dout_unused_s;

  assign game_hit_s    = (io_addr == GAME_PORT);
  assign cass_hit_s    = (io_addr == CASS_PORT);
  assign rd_ev_s       = ce && game_hit_s && !io_rd_n && prev_rd_n_q;
  assign wr_game_s     = ce && game_hit_s && !io_wr_n && prev_wr_n_q;
  assign wr_cass_s     = ce && cass_hit_s && !io_wr_n && prev_wr_n_q;
  assign motor_rise_s  = wr_cass_s && io_dout[2] && !tape_bits_q[2];
  assign rewind_s      = wr_game_s || motor_rise_s;
  // A write in the same ce wins, so the read is dropped entirely.
  assign rd_eff_s      = rd_ev_s && !wr_game_s && !wr_cass_s;
  assign addr_inc_s    = {1'b0, rom_addr_q} + {{AW{1'b0}}, 1'b1};
  assign dout_unused_s = io_dout[7:3];

  assign rd_sel    = game_hit_s && !io_rd_n;
  assign rom_addr  = rom_addr_q;
  assign rd_data   = rd_data_q;
  assign tape_bits = tape_bits_q;
  assign motor     = tape_bits_q[2];
  assign eot       = eot_q;
  assign overrun   = overrun_q;

  // Next-state: strobe history, cassette latch, prefetch FSM and rewind override.
  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    rom_addr_d  = rom_addr_q;
    buf_d       = buf_q;
    rd_data_d   = rd_data_q;
    tape_bits_d = tape_bits_q;
    overrun_d   = overrun_q;
    prev_rd_n_d = prev_rd_n_q;
    prev_wr_n_d = prev_wr_n_q;

    if (ce) begin
      prev_rd_n_d = io_rd_n;
      prev_wr_n_d = io_wr_n;
    end else begin
      prev_rd_n_d = prev_rd_n_q;
      prev_wr_n_d = prev_wr_n_q;
    end

    if (wr_cass_s) begin
      tape_bits_d = io_dout[2:0];
    end else begin
      tape_bits_d = tape_bits_q;
    end

    case (state_q)
      ST_FETCH: begin
        if (rd_eff_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        // First clock lets the ROM register the new address; second captures it.
        if (fetch_cnt_q == 1'b1) begin
          buf_d       = rom_data;
          state_d     = ST_READY;
          fetch_cnt_d = 1'b0;
        end else begin
          fetch_cnt_d = 1'b1;
        end
      end
      ST_READY: begin
        if (rd_eff_s) begin
          rd_data_d = buf_q;
          if (addr_inc_s == TAPE_END) begin
            state_d = ST_EOT;
          end else begin
            rom_addr_d  = addr_inc_s[AW-1:0];
            state_d     = ST_FETCH;
            fetch_cnt_d = 1'b0;
          end
        end else begin
          rd_data_d = rd_data_q;
        end
      end
      ST_EOT: begin
        if (rd_eff_s) begin
          rd_data_d = EOT_BYTE;
        end else begin
          rd_data_d = rd_data_q;
        end
      end
      default: begin
        state_d     = ST_FETCH;
        fetch_cnt_d = 1'b0;
      end
    endcase

    if (rewind_s) begin
      rom_addr_d  = {AW{1'b0}};
      state_d     = ST_FETCH;
      fetch_cnt_d = 1'b0;
    end else begin
      rom_addr_d  = rom_addr_d;
    end

    eot_d = (state_d == ST_EOT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      fetch_cnt_q <= 1'b0;
      rom_addr_q  <= {AW{1'b0}};
      buf_q       <= 8'h00;
      rd_data_q   <= 8'h00;
      tape_bits_q <= 3'b000;
      eot_q       <= 1'b0;
      overrun_q   <= 1'b0;
      prev_rd_n_q <= 1'b1;
      prev_wr_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      rom_addr_q  <= rom_addr_d;
      buf_q       <= buf_d;
      rd_data_q   <= rd_data_d;
      tape_bits_q <= tape_bits_d;
      eot_q       <= eot_d;
      overrun_q   <= overrun_d;
      prev_rd_n_q <= prev_rd_n_d;
      prev_wr_n_q <= prev_wr_n_d;
    end
  end

endmodule
